// File: rtl/nios_sd_loader_cpu_cpu_mult_pipe.sv
// Stallable pipelined DATA_W x DATA_W multiplier for the M-stage: unsigned lane
// products plus a sign-correction term, summed and half-selected at the tail.
module nios_sd_loader_cpu_cpu_mult_lane #(
    parameter int LANE_W = 16
) (
    input  logic [LANE_W-1:0]   a,
    input  logic [LANE_W-1:0]   b,
    output logic [2*LANE_W-1:0] p
);
    assign p = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
endmodule

module nios_sd_loader_cpu_cpu_mult_pipe #(
    parameter int DATA_W      = 32,
    parameter int LANE_W      = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_op,
    input  logic              E_valid,
    input  logic              M_en,
    output logic [DATA_W-1:0] M_mul_result,
    output logic              M_mul_valid
);
    localparam int NL = DATA_W / LANE_W;
    localparam int NP = NL * NL;
    localparam int PW = 2 * DATA_W;

    logic [NP-1:0][2*LANE_W-1:0] pp, pp_q;
    logic [DATA_W:0]             corr, corr_q;
    logic [1:0]                  op_q;
    logic [PIPE_STAGES:1]        vld_pipe;
    logic [PW-1:0]               prod;
    logic [DATA_W-1:0]           res_comb;
    logic                        signed_a, signed_b;

    genvar i, j;
    generate
        for (i = 0; i < NL; i++) begin : g_row
            for (j = 0; j < NL; j++) begin : g_col
                nios_sd_loader_cpu_cpu_mult_lane #(.LANE_W(LANE_W)) u_lane (
                    .a (E_src1[i*LANE_W +: LANE_W]),
                    .b (E_src2[j*LANE_W +: LANE_W]),
                    .p (pp[i*NL+j])
                );
            end
        end
    endgenerate

    // Signed operand = unsigned value - msb*2^W, so the product needs
    // (a_neg ? B : 0) + (b_neg ? A : 0) subtracted at weight 2^W.
    assign signed_a = E_op[1];
    assign signed_b = (E_op == 2'd3);

    always_comb begin
        corr = '0;
        if (signed_a && E_src1[DATA_W-1]) corr = corr + {1'b0, E_src2};
        if (signed_b && E_src2[DATA_W-1]) corr = corr + {1'b0, E_src1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pp_q   <= '0;
            corr_q <= '0;
            op_q   <= '0;
        end else if (M_en) begin
            pp_q   <= pp;
            corr_q <= corr;
            op_q   <= E_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (M_en) begin
            vld_pipe[1] <= E_valid;
            for (int s = 2; s <= PIPE_STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    always_comb begin
        prod = '0;
        for (int k = 0; k < NP; k++)
            prod = prod + (PW'(pp_q[k]) << (LANE_W * ((k / NL) + (k % NL))));
        prod = prod - (PW'(corr_q) << DATA_W);
    end

    assign res_comb = (op_q == 2'd0) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];

    // Stages past the first are plain registers after the adder tree; synthesis
    // retiming is expected to push them back into the sum.
    generate
        if (PIPE_STAGES == 1) begin : g_one
            assign M_mul_result = res_comb;
        end else begin : g_ret
            logic [PIPE_STAGES-2:0][DATA_W-1:0] res_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    res_q <= '0;
                end else if (M_en) begin
                    res_q[0] <= res_comb;
                    for (int s = 1; s < PIPE_STAGES - 1; s++) res_q[s] <= res_q[s-1];
                end
            end
            assign M_mul_result = res_q[PIPE_STAGES-2];
        end
    endgenerate

    assign M_mul_valid = vld_pipe[PIPE_STAGES];
endmodule
